// File: rtl/param_mem_responder_pkg.sv
// Shared mixer package: memory geometry and the bank-swap state encoding,
// used by both the parameter responder and dsp_core.
package param_mem_responder_pkg;

  localparam int unsigned DATA_W = 36;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;

  // Swap sequencing: a request waits in SwapPending until the next frame boundary.
  typedef enum logic {
    SwapIdle,
    SwapPending
  } swap_state_e;

endpackage

// File: rtl/placeholder_interface.sv
// DSP-side parameter memory port. dsp_core drives it as initiator; the
// parameter responder answers as responder.
//   rd_en/rd_addr   : read request, data returned one cycle later on rd_data
//   wr_en/wr_addr/wr_data : write into the active bank
interface placeholder_interface #(
  parameter int unsigned DATA_W = param_mem_responder_pkg::DATA_W,
  parameter int unsigned ADDR_W = param_mem_responder_pkg::ADDR_W
);

  logic                     rd_en;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;

  modport responder (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
    output rd_data
  );

  modport initiator (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data,
    input  rd_data
  );

endinterface

// File: rtl/param_bank_ram.sv
// One parameter bank: simple dual-port RAM, one write port, one registered
// read port (read-first), written to map onto block RAM. No reset on purpose.
//   clk              : clock
//   we/waddr/wdata   : write port
//   re/raddr/rdata   : read port, rdata updated on the edge re is sampled
module param_bank_ram #(
  parameter int unsigned DATA_W = 36,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/param_mem_responder.sv
// Double-buffered parameter memory. The DSP reads/writes the active bank
// through the mem interface; the host fills the shadow bank. A swap request
// is held pending and applied at the next frame_start.
//   clk, reset      : clock, synchronous active-high reset
//   mem             : DSP port (responder end)
//   host_wr_en/host_addr/host_data : host write into the shadow bank
//   swap_req        : request a bank swap at the next frame boundary
//   frame_start     : frame boundary strobe
//   swap_pending    : swap requested but not yet applied
//   swap_done       : one-cycle pulse, first cycle with the new bank_sel
//   bank_sel        : index of the active bank
module param_mem_responder #(
  parameter int unsigned DATA_W = param_mem_responder_pkg::DATA_W,
  parameter int unsigned ADDR_W = param_mem_responder_pkg::ADDR_W,
  parameter int unsigned DEPTH  = param_mem_responder_pkg::DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  placeholder_interface.responder  mem,
  input  logic                     host_wr_en,
  input  logic [ADDR_W-1:0]        host_addr,
  input  logic signed [DATA_W-1:0] host_data,
  input  logic                     swap_req,
  input  logic                     frame_start,
  output logic                     swap_pending,
  output logic                     swap_done,
  output logic                     bank_sel
);

  import param_mem_responder_pkg::swap_state_e;
  import param_mem_responder_pkg::SwapIdle;
  import param_mem_responder_pkg::SwapPending;

  swap_state_e state_q, state_d;
  logic        bank_sel_q, bank_sel_d;
  logic        swap_done_q, swap_done_d;

  // Accesses presented during reset are dropped.
  logic rd_en_g, wr_en_g, host_en_g;
  assign rd_en_g   = mem.rd_en & ~reset;
  assign wr_en_g   = mem.wr_en & ~reset;
  assign host_en_g = host_wr_en & ~reset;

  logic [DATA_W-1:0] ram_rdata [2];

  // Each bank has exactly one writer at a time: the DSP when active, the
  // host when shadow. bank_sel_q is the pre-swap value during the swap cycle.
  for (genvar i = 0; i < 2; i++) begin : g_bank
    logic              is_active;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;

    assign is_active = (bank_sel_q == 1'(i));
    assign we        = is_active ? wr_en_g : host_en_g;
    assign waddr     = is_active ? mem.wr_addr : host_addr;
    assign wdata     = is_active ? DATA_W'(mem.wr_data) : DATA_W'(host_data);

    param_bank_ram #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DEPTH (DEPTH)
    ) u_ram (
      .clk  (clk),
      .we   (we),
      .waddr(waddr),
      .wdata(wdata),
      .re   (rd_en_g),
      .raddr(mem.rd_addr),
      .rdata(ram_rdata[i])
    );
  end

  // Read return path: bank select and write-bypass are captured alongside
  // the RAM read; a hold register keeps rd_data stable between reads.
  logic              rd_valid_q, rd_sel_q, byp_q;
  logic [DATA_W-1:0] byp_data_q, rd_hold_q, rd_data_int;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      rd_hold_q  <= '0;
    end else begin
      rd_valid_q <= rd_en_g;
      rd_sel_q   <= bank_sel_q;
      byp_q      <= rd_en_g & wr_en_g & (mem.rd_addr == mem.wr_addr);
      byp_data_q <= DATA_W'(mem.wr_data);
      rd_hold_q  <= rd_data_int;
    end
  end

  always_comb begin
    rd_data_int = rd_hold_q;
    if (rd_valid_q) rd_data_int = byp_q ? byp_data_q : ram_rdata[rd_sel_q];
  end

  assign mem.rd_data = $signed(rd_data_int);

  // Swap FSM.
  always_comb begin
    state_d     = state_q;
    bank_sel_d  = bank_sel_q;
    swap_done_d = 1'b0;
    unique case (state_q)
      SwapIdle: begin
        // frame_start alongside the request is not a boundary for it.
        if (swap_req) state_d = SwapPending;
      end
      SwapPending: begin
        if (frame_start) begin
          state_d     = SwapIdle;
          bank_sel_d  = ~bank_sel_q;
          swap_done_d = 1'b1;
        end
      end
      default: state_d = SwapIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SwapIdle;
      bank_sel_q  <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_sel_q  <= bank_sel_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign swap_pending = (state_q == SwapPending);
  assign swap_done    = swap_done_q;
  assign bank_sel     = bank_sel_q;

endmodule

// File: tb/tb_param_mem_responder.sv
// Scoreboard bench for param_mem_responder: stimulus updates a two-bank
// reference model and queues expected results; a monitor compares after
// every rising edge.
module tb_param_mem_responder;

  localparam int DW = 36;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_wr_en;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_data;
  logic          swap_req;
  logic          frame_start;
  logic          swap_pending;
  logic          swap_done;
  logic          bank_sel;

  placeholder_interface #(.DATA_W(DW), .ADDR_W(AW)) mem_if ();

  param_mem_responder #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .DEPTH (1024)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mem_if),
    .host_wr_en  (host_wr_en),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .swap_req    (swap_req),
    .frame_start (frame_start),
    .swap_pending(swap_pending),
    .swap_done   (swap_done),
    .bank_sel    (bank_sel)
  );

  always #5 clk = ~clk;

  // Reference state.
  logic [DW-1:0] model [2][1024];
  logic          m_sel;
  logic          m_pend;
  logic [DW-1:0] rd_q [$];
  logic [2:0]    st_q [$];   // {bank_sel, swap_pending, swap_done}

  int checks = 0;
  int errors = 0;

  function automatic logic [DW-1:0] r36();
    return {4'($urandom()), 32'($urandom())};
  endfunction

  // Addresses the bench reads: 0..15 and 1020..1023, all initialised first.
  function automatic logic [AW-1:0] pool_addr(int i);
    return (i < 16) ? AW'(i) : AW'(1004 + i);
  endfunction

  // Apply the current inputs to the model as if the next rising edge happened.
  task automatic model_edge();
    logic done;
    done = 1'b0;
    if (reset) begin
      m_sel  = 1'b0;
      m_pend = 1'b0;
    end else begin
      if (mem_if.rd_en) begin
        if (mem_if.wr_en && mem_if.wr_addr == mem_if.rd_addr) rd_q.push_back(mem_if.wr_data);
        else rd_q.push_back(model[m_sel][mem_if.rd_addr]);
      end
      if (mem_if.wr_en) model[m_sel][mem_if.wr_addr] = mem_if.wr_data;
      if (host_wr_en) model[!m_sel][host_addr] = host_data;
      if (m_pend && frame_start) begin
        m_sel  = !m_sel;
        m_pend = 1'b0;
        done   = 1'b1;
      end else if (!m_pend && swap_req) begin
        m_pend = 1'b1;
      end
    end
    st_q.push_back({m_sel, m_pend, done});
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    reset          = 1'b0;
    mem_if.rd_en   = 1'b0;
    mem_if.wr_en   = 1'b0;
    host_wr_en     = 1'b0;
    swap_req       = 1'b0;
    frame_start    = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    mem_if.rd_en   = 1'b1;
    mem_if.rd_addr = a;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_if.wr_en   = 1'b1;
    mem_if.wr_addr = a;
    mem_if.wr_data = d;
  endtask

  task automatic do_host(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_wr_en = 1'b1;
    host_addr  = a;
    host_data  = d;
  endtask

  // Monitor.
  initial begin
    logic          issued;
    logic          rst;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] last_rd;
    logic [2:0]    st;
    last_rd = '0;
    forever begin
      @(posedge clk);
      issued = mem_if.rd_en && !reset;
      rst    = reset;
      #1;
      if (st_q.size() > 0) begin
        st = st_q.pop_front();
        checks++;
        if (bank_sel !== st[2]) begin
          errors++;
          $display("FAIL bank_sel t=%0t got %b want %b", $time, bank_sel, st[2]);
        end
        checks++;
        if (swap_pending !== st[1]) begin
          errors++;
          $display("FAIL swap_pending t=%0t got %b want %b", $time, swap_pending, st[1]);
        end
        checks++;
        if (swap_done !== st[0]) begin
          errors++;
          $display("FAIL swap_done t=%0t got %b want %b", $time, swap_done, st[0]);
        end
      end
      exp_rd = last_rd;
      if (rst) begin
        exp_rd = '0;
      end else if (issued) begin
        if (rd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_queue_underflow t=%0t got empty want entry", $time);
        end else begin
          exp_rd = rd_q.pop_front();
        end
      end
      checks++;
      if (mem_if.rd_data !== exp_rd) begin
        errors++;
        $display("FAIL rd_data t=%0t got %h want %h", $time, mem_if.rd_data, exp_rd);
      end
      last_rd = exp_rd;
    end
  end

  // Stimulus.
  initial begin
    m_sel  = 1'b0;
    m_pend = 1'b0;
    idle();
    reset          = 1'b1;
    mem_if.rd_addr = '0;
    mem_if.wr_addr = '0;
    mem_if.wr_data = '0;
    host_addr      = '0;
    host_data      = '0;
    @(negedge clk);
    step();
    step();

    // Fill both banks at every address the bench reads.
    for (int i = 0; i < 20; i++) begin
      idle();
      do_write(pool_addr(i), r36());
      do_host(pool_addr(i), r36());
      step();
    end

    // Host 0x123 to addr 5, swap, DSP reads it back.
    idle(); do_host(10'd5, 36'h123); step();
    idle(); swap_req = 1'b1; step();
    idle(); step();
    idle(); frame_start = 1'b1; step();
    idle(); do_read(10'd5); step();
    idle(); step();

    // Bypass at the top address, then expose the shadow copy.
    idle(); do_write(10'd1023, 36'h7_FFFF_FFFF); do_read(10'd1023); step();
    idle(); swap_req = 1'b1; step();
    idle(); frame_start = 1'b1; step();
    idle(); do_read(10'd1023); step();
    idle(); step();

    // Read in the swap cycle returns old data; next read returns new.
    idle(); do_host(10'd5, 36'h456); swap_req = 1'b1; step();
    idle(); frame_start = 1'b1; do_read(10'd5); step();
    idle(); do_read(10'd5); step();

    // Double request, double frame_start: one toggle.
    idle(); swap_req = 1'b1; step();
    idle(); swap_req = 1'b1; step();
    idle(); frame_start = 1'b1; step();
    idle(); frame_start = 1'b1; step();

    // Request with frame_start in idle only arms; lone frame_start in idle is inert.
    idle(); frame_start = 1'b1; step();
    idle(); swap_req = 1'b1; frame_start = 1'b1; step();
    idle(); frame_start = 1'b1; step();

    // Reset while pending; accesses during reset are dropped; memory survives.
    idle(); do_write(10'd7, 36'hA_BCDE_F012); step();
    idle(); swap_req = 1'b1; step();
    idle(); reset = 1'b1; do_read(10'd7); do_write(10'd7, 36'h1); do_host(10'd7, 36'h2); step();
    idle(); do_read(10'd7); step();
    idle(); do_read(10'd3); step();

    // Host write to shadow is invisible to the DSP.
    idle(); do_host(10'd0, {DW{1'b1}}); step();
    idle(); do_read(10'd0); step();
    idle(); step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset          = ($urandom_range(0, 99) == 0);
      mem_if.rd_en   = $urandom_range(0, 1) == 1;
      mem_if.rd_addr = pool_addr($urandom_range(0, 19));
      mem_if.wr_en   = $urandom_range(0, 9) < 3;
      mem_if.wr_addr = ($urandom_range(0, 3) == 0) ? mem_if.rd_addr : pool_addr($urandom_range(0, 19));
      mem_if.wr_data = r36();
      host_wr_en     = $urandom_range(0, 9) < 3;
      host_addr      = pool_addr($urandom_range(0, 19));
      host_data      = r36();
      swap_req       = $urandom_range(0, 19) == 0;
      frame_start    = $urandom_range(0, 9) == 0;
      step();
    end

    idle();
    step();
    step();
    @(posedge clk);
    #2;
    checks++;
    if (rd_q.size() != 0 || st_q.size() != 0) begin
      errors++;
      $display("FAIL drain got rd=%0d st=%0d want 0 0", rd_q.size(), st_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_mem_responder.md
PARAM_MEM_RESPONDER -- requirements
Module: param_mem_responder

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- DATA_W, 36, word width.
- ADDR_W, 10, address width.
- DEPTH, 1024, words per bank (2**ADDR_W).

REQ-002 SHALL have the following ports, one clock, reset synchronous and active-high:
- clk  in  1  sole clock, all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- mem.rd_en  in  1  DSP read request.
- mem.rd_addr  in  10  DSP read address.
- mem.rd_data  out  36 signed  DSP read data.
- mem.wr_en  in  1  DSP write request.
- mem.wr_addr  in  10  DSP write address.
- mem.wr_data  in  36 signed  DSP write data.
- host_wr_en  in  1  host write to shadow bank.
- host_addr  in  10  host write address.
- host_data  in  36 signed  host write data.
- swap_req  in  1  one-cycle request to swap banks at next frame boundary.
- frame_start  in  1  one-cycle frame boundary strobe from DSP sequencer.
- swap_pending  out  1  swap requested, not yet applied.
- swap_done  out  1  one-cycle pulse, cycle after swap applied.
- bank_sel  out  1  index of bank currently active (DSP-facing).

REQ-003 SHALL expose the mem.* signals through placeholder_interface, acting as the responder end; dsp_core is the initiator.

Function
REQ-004 SHALL hold two banks of DEPTH x DATA_W; bank[bank_sel] is active, bank[~bank_sel] is shadow.
REQ-005 DSP read: rd_en at cycle N SHALL present bank[active][rd_addr] on rd_data at cycle N+1 (latency 1, registered).
REQ-006 rd_data SHALL hold its last value when rd_en is low.
REQ-007 DSP write: wr_en SHALL write wr_data to active bank at wr_addr, visible to reads issued from cycle N+1.
REQ-008 Same-cycle rd_en and wr_en to the same address SHALL bypass, returning the new wr_data at N+1.
REQ-009 Host write: host_wr_en SHALL write host_data to shadow bank at host_addr; never stalls, no ready signal.
REQ-010 Host writes SHALL never alter the active bank, and DSP writes SHALL never alter the shadow bank.
REQ-011 Swap FSM states and transitions:
- IDLE --swap_req--> PENDING.
- PENDING --frame_start--> IDLE, with bank_sel toggled at the next edge.
REQ-012 swap_pending SHALL be 1 exactly while in PENDING.
REQ-013 swap_req while PENDING SHALL be ignored (no double toggle).
REQ-014 swap_req and frame_start in the same cycle while in IDLE SHALL enter PENDING only; the swap occurs at the next frame_start.
REQ-015 frame_start while in IDLE SHALL have no effect.
REQ-016 In the swap cycle:
- DSP read/write and host write SHALL use the pre-swap bank_sel.
- A read issued that cycle SHALL return pre-swap active data.
REQ-017 swap_done SHALL pulse high for one cycle, the first cycle bank_sel shows the new value.
REQ-018 After a swap the new shadow bank holds the old active contents unchanged; no copy-back is performed.
REQ-019 Addresses SHALL be full-range with no wrap or bounds logic; data SHALL pass bit-exact with no arithmetic.

Reset
REQ-020 reset SHALL force: state IDLE, bank_sel 0, rd_data 0, swap_pending 0, swap_done 0.
REQ-021 Memory contents SHALL NOT be cleared by reset.
REQ-022 Reset asserted while PENDING SHALL cancel the pending swap.
REQ-023 Reads and writes presented while reset is high SHALL be ignored.

Structure
REQ-024 DATA_W, ADDR_W, DEPTH and the swap-state enum (IDLE, PENDING) SHALL live in the shared mixer package used by dsp_core.
REQ-025 Each bank SHALL be one instance of sub-module param_bank_ram:
- simple dual-port, 1 write port and 1 registered read port.
- inferable as block RAM.
- bypass and bank muxing kept outside param_bank_ram.

Verification
REQ-026 Host writes 0x123 to addr 5, swap_req, frame_start, DSP reads addr 5 -> rd_data = 0x123 one cycle after rd_en; swap_done pulses once.
REQ-027 DSP write 0x7_FFFF_FFFF and read addr 1023 in the same cycle -> next-cycle rd_data = 0x7_FFFF_FFFF; shadow addr 1023 unchanged.
REQ-028 Read addr 5 issued in the frame_start swap cycle -> returns old active value; a read issued the next cycle returns new value.
REQ-029 Two swap_req before frame_start, then two frame_start -> bank_sel toggles exactly once.
REQ-030 Reset asserted during PENDING:
- swap_pending = 0, bank_sel = 0, rd_data = 0.
- Previously written bank contents still readable after reset.
REQ-031 Host write -0x1 to addr 0 without a swap -> DSP read of addr 0 returns the active value, not -0x1.
